// File: rtl/cam_dvp_if.sv
// DVP source bus: run control in, sensor-style sync/data out.
// master = camera source, slave = capture consumer.
interface cam_dvp_if;
    logic       i_enable;
    logic [1:0] i_pattern;
    logic       o_vsync;
    logic       o_href;
    logic [7:0] o_data;
    logic       o_frame_done;
    logic       o_busy;

    modport master (
        input  i_enable, i_pattern,
        output o_vsync, o_href, o_data, o_frame_done, o_busy
    );

    modport slave (
        output i_enable, i_pattern,
        input  o_vsync, o_href, o_data, o_frame_done, o_busy
    );
endinterface

// File: rtl/cam_dvp_tx.sv
// Camera-side DVP source: emits RGB565 frames (two bytes per pixel) from
// built-in test patterns with OV7670-style vsync/href framing.
// Outputs are registered from the next-state decode, so every output is a
// flop that reflects the state the FSM is in during that cycle.
module cam_dvp_tx #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 288,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic      i_clk,
    input  logic      i_rst,
    cam_dvp_if.master dvp
);
    localparam int T_LINE  = 2 * H_ACTIVE + H_BLANK;
    localparam int VS_LEN  = VSYNC_LINES * T_LINE;
    localparam int VB_LEN  = V_BACK * T_LINE;
    localparam int VF_LEN  = V_FRONT * T_LINE;
    localparam int ACT_LEN = 2 * H_ACTIVE;
    localparam int M1      = (VS_LEN > VB_LEN) ? VS_LEN : VB_LEN;
    localparam int M2      = (VF_LEN > ACT_LEN) ? VF_LEN : ACT_LEN;
    localparam int M3      = (M1 > M2) ? M1 : M2;
    localparam int CNT_MAX = (M3 > H_BLANK) ? M3 : H_BLANK;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int XW      = $clog2(H_ACTIVE);
    localparam int YW      = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [CW-1:0] VS_LAST  = CW'(VS_LEN - 1);
    localparam logic [CW-1:0] VB_LAST  = CW'(VB_LEN - 1);
    localparam logic [CW-1:0] VF_LAST  = CW'(VF_LEN - 1);
    localparam logic [CW-1:0] ACT_LAST = CW'(ACT_LEN - 1);
    localparam logic [CW-1:0] HB_LAST  = CW'(H_BLANK - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_ACTIVE - 1);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, BLANK, VFRONT} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;             // cycles spent in current state
    logic [YW-1:0] y, y_n;                 // active line index
    logic [2:0]    bar_idx, bar_idx_n;     // colour bar index, no divider
    logic [BW-1:0] bar_pos, bar_pos_n;     // pixel within current bar
    logic [7:0]    frame_cnt, frame_cnt_n;
    logic [7:0]    fc_lat, fc_n;           // frame count frozen for this frame
    logic [1:0]    pat_lat, pat_n;         // pattern frozen for this frame
    logic          start_frame;
    logic          done_n;
    logic [XW-1:0] x_n;
    logic [15:0]   xe, ye, pix;
    logic [7:0]    data_n;

    // Next-state, counters and the pixel byte for the upcoming cycle.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt + 1'b1;
        y_n         = y;
        bar_idx_n   = bar_idx;
        bar_pos_n   = bar_pos;
        frame_cnt_n = frame_cnt;
        pat_n       = pat_lat;
        fc_n        = fc_lat;
        start_frame = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (dvp.i_enable) start_frame = 1'b1;
            end
            VSYNC: if (cnt == VS_LAST) begin
                state_n = VBACK;
                cnt_n   = '0;
            end
            VBACK: if (cnt == VB_LAST) begin
                state_n   = ACTIVE;
                cnt_n     = '0;
                y_n       = '0;
                bar_idx_n = '0;
                bar_pos_n = '0;
            end
            ACTIVE: begin
                // Advance the bar position after the second byte of a pixel.
                if (cnt[0]) begin
                    if (bar_pos == BAR_LAST) begin
                        bar_pos_n = '0;
                        bar_idx_n = bar_idx + 1'b1;
                    end else begin
                        bar_pos_n = bar_pos + 1'b1;
                    end
                end
                if (cnt == ACT_LAST) begin
                    state_n = BLANK;
                    cnt_n   = '0;
                end
            end
            BLANK: if (cnt == HB_LAST) begin
                cnt_n     = '0;
                bar_idx_n = '0;
                bar_pos_n = '0;
                if (y == Y_LAST) begin
                    state_n = VFRONT;
                end else begin
                    state_n = ACTIVE;
                    y_n     = y + 1'b1;
                end
            end
            VFRONT: if (cnt == VF_LAST) begin
                cnt_n       = '0;
                frame_cnt_n = frame_cnt + 1'b1;
                state_n     = IDLE;
                if (dvp.i_enable) start_frame = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        // Frame start latches pattern and the (already bumped) frame count.
        if (start_frame) begin
            state_n = VSYNC;
            cnt_n   = '0;
            pat_n   = dvp.i_pattern;
            fc_n    = frame_cnt_n;
        end
        done_n = (state_n == VFRONT) && (cnt_n == VF_LAST);

        x_n = cnt_n[XW:1];
        xe  = 16'(x_n);
        ye  = 16'(y_n);
        case (pat_n)
            2'd0: case (bar_idx_n)
                3'd0:    pix = 16'hFFFF;
                3'd1:    pix = 16'hFFE0;
                3'd2:    pix = 16'h07FF;
                3'd3:    pix = 16'h07E0;
                3'd4:    pix = 16'hF81F;
                3'd5:    pix = 16'hF800;
                3'd6:    pix = 16'h001F;
                default: pix = 16'h0000;
            endcase
            2'd1:    pix = xe;
            2'd2:    pix = {fc_n, fc_n};
            default: pix = (xe[3] ^ ye[3]) ? 16'hFFFF : 16'h0000;
        endcase
        data_n = 8'h00;
        if (state_n == ACTIVE) data_n = cnt_n[0] ? pix[7:0] : pix[15:8];
    end

    // State, counters and registered outputs; reset abandons any partial line.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state            <= IDLE;
            cnt              <= '0;
            y                <= '0;
            bar_idx          <= '0;
            bar_pos          <= '0;
            frame_cnt        <= '0;
            fc_lat           <= '0;
            pat_lat          <= '0;
            dvp.o_vsync      <= 1'b0;
            dvp.o_href       <= 1'b0;
            dvp.o_data       <= '0;
            dvp.o_frame_done <= 1'b0;
            dvp.o_busy       <= 1'b0;
        end else begin
            state            <= state_n;
            cnt              <= cnt_n;
            y                <= y_n;
            bar_idx          <= bar_idx_n;
            bar_pos          <= bar_pos_n;
            frame_cnt        <= frame_cnt_n;
            fc_lat           <= fc_n;
            pat_lat          <= pat_n;
            dvp.o_vsync      <= (state_n == VSYNC);
            dvp.o_href       <= (state_n == ACTIVE);
            dvp.o_data       <= data_n;
            dvp.o_frame_done <= done_n;
            dvp.o_busy       <= (state_n != IDLE);
        end
    end
endmodule

// File: tb/tb_cam_dvp_tx.sv
// Bench for cam_dvp_tx in the small configuration: every output is compared
// each cycle against a frame-timeline model computed from cycle offsets.
module tb_cam_dvp_tx;
    localparam int H   = 16;
    localparam int VA  = 4;
    localparam int HB  = 8;
    localparam int VSL = 2;
    localparam int VB  = 1;
    localparam int VF  = 1;
    localparam int TL  = 2 * H + HB;
    localparam int FR  = (VSL + VB + VA + VF) * TL;
    localparam int ACT0 = (VSL + VB) * TL;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cur_t = 0;

    cam_dvp_if dvp();

    cam_dvp_tx #(
        .H_ACTIVE(H), .V_ACTIVE(VA), .H_BLANK(HB),
        .VSYNC_LINES(VSL), .V_BACK(VB), .V_FRONT(VF)
    ) u_dut (
        .i_clk(clk),
        .i_rst(rst),
        .dvp  (dvp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s t=%0d got=%h exp=%h", tag, cur_t, got, exp);
        end
    endtask

    // RGB565 value of a pixel, straight from the pattern definitions.
    function automatic logic [15:0] pix(input int pat, input int x, input int y, input int fc);
        logic [7:0] f;
        f = 8'(fc % 256);
        case (pat)
            0: case (x / (H / 8))
                0: return 16'hFFFF;
                1: return 16'hFFE0;
                2: return 16'h07FF;
                3: return 16'h07E0;
                4: return 16'hF81F;
                5: return 16'hF800;
                6: return 16'h001F;
                default: return 16'h0000;
            endcase
            1: return 16'(x);
            2: return {f, f};
            default: return (((x / 8) + (y / 8)) % 2 == 1) ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    // Expected outputs at cycle t of a frame (t=0 is the first vsync cycle).
    task automatic model(input int t, input int pat, input int fc,
                         output logic v, output logic h, output logic fd,
                         output logic [7:0] d);
        int t2, c;
        logic [15:0] p;
        v  = (t < VSL * TL);
        fd = (t == FR - 1);
        h  = 1'b0;
        d  = 8'h00;
        t2 = t - ACT0;
        if (t2 >= 0 && t2 < VA * TL) begin
            c = t2 % TL;
            if (c < 2 * H) begin
                h = 1'b1;
                p = pix(pat, c / 2, t2 / TL, fc);
                d = (c % 2 == 1) ? p[7:0] : p[15:8];
            end
        end
    endtask

    // Checks ncyc cycles of one frame; random noise on inputs is applied
    // mid-frame, and on the last cycle the continue request is driven.
    task automatic run_frame(input int pat, input int fc, input bit cont,
                             input int next_pat, input int ncyc);
        logic v, h, fd;
        logic [7:0] d;
        for (int t = 0; t < ncyc; t++) begin
            @(posedge clk);
            #1;
            cur_t = t;
            model(t, pat, fc, v, h, fd, d);
            chk("vsync", 8'(dvp.o_vsync), 8'(v));
            chk("href", 8'(dvp.o_href), 8'(h));
            chk("data", dvp.o_data, d);
            chk("frame_done", 8'(dvp.o_frame_done), 8'(fd));
            chk("busy", 8'(dvp.o_busy), 8'd1);
            if (t == FR - 1) begin
                dvp.i_enable  = cont;
                dvp.i_pattern = 2'(next_pat);
            end else begin
                dvp.i_pattern = 2'($urandom);
                if (($urandom & 3) == 0) dvp.i_enable = ~dvp.i_enable;
            end
        end
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cur_t = i;
            checks++;
            assert ({dvp.o_vsync, dvp.o_href, dvp.o_data, dvp.o_frame_done, dvp.o_busy} === 12'h000)
            else begin
                failures++;
                $error("FAIL %s t=%0d got=%b_%b_%h_%b_%b exp=all-zero", tag, i, dvp.o_vsync,
                       dvp.o_href, dvp.o_data, dvp.o_frame_done, dvp.o_busy);
            end
            dvp.i_pattern = 2'($urandom);
        end
    endtask

    int pats[7];
    int fc;

    initial begin
        dvp.i_enable  = 1'b0;
        dvp.i_pattern = 2'd0;
        // Reset, then idle with enable low.
        repeat (3) @(posedge clk);
        #1;
        idle_check("reset", 1);
        rst = 1'b0;
        idle_check("idle_hold", 500);

        // Back-to-back chain: directed patterns then random ones; enable
        // noise mid-frame must be ignored, last frame drops enable.
        pats = '{0, 1, 3, 2, 2, 0, 0};
        pats[5] = int'($urandom_range(0, 3));
        pats[6] = int'($urandom_range(0, 3));
        dvp.i_pattern = 2'(pats[0]);
        dvp.i_enable  = 1'b1;
        fc = 0;
        for (int k = 0; k < 7; k++) begin
            run_frame(pats[k], fc, k < 6, (k < 6) ? pats[(k < 6) ? k + 1 : k] : 0, FR);
            fc++;
        end
        idle_check("after_drop", 200);

        // Partial frame, then a one-cycle reset in the middle of line 0.
        dvp.i_pattern = 2'd1;
        dvp.i_enable  = 1'b1;
        run_frame(1, fc, 1'b1, 1, ACT0 + 5);
        rst = 1'b1;
        dvp.i_enable = 1'b1;
        idle_check("mid_reset", 1);
        rst = 1'b0;
        dvp.i_pattern = 2'd2;
        dvp.i_enable  = 1'b1;
        // Counter restarts at 0: solid 0000, 0101, 0202 with no gap.
        run_frame(2, 0, 1'b1, 2, FR);
        run_frame(2, 1, 1'b1, 2, FR);
        run_frame(2, 2, 1'b0, 0, FR);
        idle_check("final_idle", 50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
